uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter NUMBER_OF_BITS, default 8, meaning data bits per frame.
REQ-002 The block SHALL have parameter BAUD_DIVIDER, default 4, meaning clock cycles per bit, with legal range >= 2.
REQ-003 The block SHALL have port clock  input  1  system clock, with all logic on the rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 The block SHALL have port data_valid  output  1  received word available.
REQ-007 The block SHALL have port data_ready  input  1  consumer accepts word.
REQ-008 The block SHALL have port data_bits  output  NUMBER_OF_BITS  received word, LSB first on the line.
REQ-009 The block SHALL have port framing_error  output  1  one-cycle pulse on a bad stop bit.
REQ-010 The block SHALL have port overrun  output  1  one-cycle pulse when a word is dropped.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (rx_s), so rx_s lags rx by 2 cycles.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP and BREAK.
REQ-013 Let HALF = BAUD_DIVIDER/2 (floor) and S = the cycle in IDLE where rx_s==0; the FSM SHALL go IDLE->START at S.
REQ-014 The start bit SHALL be sampled at S+HALF: rx_s==1 is a false start (->IDLE, no outputs); rx_s==0 ->DATA.
REQ-015 Data bit k (k=0..NUMBER_OF_BITS-1) SHALL be sampled at S+HALF+(k+1)*BAUD_DIVIDER and shifted in LSB first.
REQ-016 The stop bit SHALL be sampled at S+HALF+(NUMBER_OF_BITS+1)*BAUD_DIVIDER.
REQ-017 A stop sample of 1 with the output buffer empty SHALL load data_bits and set data_valid on the next cycle; the FSM then goes ->IDLE.
REQ-018 A stop sample of 0 SHALL pulse framing_error for 1 cycle, leave data_valid and data_bits unchanged, and go ->BREAK.
REQ-019 BREAK SHALL hold until rx_s==1, then go ->IDLE.
REQ-020 data_valid SHALL stay high until the cycle with data_valid && data_ready, and clear on the next cycle.
REQ-021 data_bits SHALL be stable while data_valid is high.
REQ-022 If a good stop bit arrives while data_valid && !data_ready, the new word SHALL be discarded, the old word retained, and overrun pulsed for 1 cycle.
REQ-023 If the handshake completes in the same cycle as a good stop sample, the new word SHALL load, data_valid SHALL stay high, and overrun SHALL NOT assert.
REQ-024 The bit-rate counter SHALL be $clog2(BAUD_DIVIDER) wide and reload BAUD_DIVIDER-1 at each sample point.
REQ-025 The bit counter SHALL be $clog2(NUMBER_OF_BITS+1) wide.
REQ-026 The receiver SHALL accept a new start bit immediately after the stop sample, so back-to-back frames with one stop bit are received without loss.

Reset
REQ-027 Reset SHALL set state=IDLE, both synchronizer flops=1, data_valid=0, framing_error=0, overrun=0, data_bits=0, and all counters=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame, with no valid, error or overrun pulse afterwards.
REQ-029 After reset release the block SHALL require rx_s==0 in IDLE before starting a frame.

Structure
REQ-030 Package uart_pkg SHALL hold typedef uart_rx_state_t (the FSM enum) and the default localparams for NUMBER_OF_BITS and BAUD_DIVIDER.
REQ-031 The synchronizer SHALL be a sub-module bit_sync with parameter STAGES (default 2) and reset value 1.

Verification (NUMBER_OF_BITS=8, BAUD_DIVIDER=4, HALF=2, bit=4 cycles)
REQ-032 A frame of 0x55 with ready held high SHALL give data_valid at S+39, data_bits=0x55, valid high for 1 cycle, and no errors.
REQ-033 A 1-cycle low glitch on idle rx SHALL produce no data_valid, no framing_error, and return to IDLE by S+2.
REQ-034 A frame of 0xA5 with stop bit 0, then rx held low for 20 cycles, then high, then a frame of 0x3C SHALL give one framing_error pulse, then data_valid with 0x3C only.
REQ-035 Back-to-back frames 0x12, 0x34 with ready low until after the second stop SHALL give overrun pulsed once, data_bits=0x12 retained, and valid held.
REQ-036 Back-to-back frames 0xA5, 0x3C with one stop bit and ready high SHALL give two valid pulses, 40 cycles apart, with the correct data.
REQ-037 Reset asserted during data bit 3 of a frame, then a clean frame 0xF0, SHALL give only 0xF0 and no error pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART receiver.
package uart_pkg;

    localparam int DEFAULT_NUMBER_OF_BITS = 8;
    localparam int DEFAULT_BAUD_DIVIDER   = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bus of uart_rx: one buffered word plus error pulses.
// data_valid rises when a word is buffered and holds, with data_bits stable, until a
// cycle where data_valid && data_ready; that cycle is the transfer and valid drops after it.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int NUMBER_OF_BITS = DEFAULT_NUMBER_OF_BITS
) ();

    logic                      data_valid;
    logic                      data_ready;
    logic [NUMBER_OF_BITS-1:0] data_bits;
    logic                      framing_error;
    logic                      overrun;

    modport master (
        output data_valid,
        output data_bits,
        output framing_error,
        output overrun,
        input  data_ready
    );

    modport slave (
        input  data_valid,
        input  data_bits,
        input  framing_error,
        input  overrun,
        output data_ready
    );

endinterface

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit with a configurable reset value.
module bit_sync #(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= {STAGES{RESET_VALUE}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop detection feeding a one-word output buffer.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NUMBER_OF_BITS = DEFAULT_NUMBER_OF_BITS,
    parameter int BAUD_DIVIDER   = DEFAULT_BAUD_DIVIDER
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           rx,
    uart_rx_if.master      bus,
    output uart_rx_state_t o_state
);

    localparam int CNT_W = $clog2(BAUD_DIVIDER);
    localparam int BIT_W = $clog2(NUMBER_OF_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BAUD_DIVIDER - 1);
    localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(BAUD_DIVIDER / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(NUMBER_OF_BITS - 1);

    uart_rx_state_t            r_state;
    uart_rx_state_t            w_state_next;
    logic [CNT_W-1:0]          r_baud_cnt;
    logic [CNT_W-1:0]          w_baud_cnt_next;
    logic [BIT_W-1:0]          r_bit_cnt;
    logic [BIT_W-1:0]          w_bit_cnt_next;
    logic [NUMBER_OF_BITS-1:0] r_shift;
    logic [NUMBER_OF_BITS-1:0] r_data_bits;
    logic                      r_data_valid;
    logic                      r_framing_error;
    logic                      r_overrun;
    logic                      w_rx_s;
    logic                      w_sample;
    logic                      w_shift;
    logic                      w_load;
    logic                      w_drop;
    logic                      w_bad_stop;
    logic                      w_handshake;

    bit_sync #(
        .STAGES      (2),
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clock   (clock),
        .reset   (reset),
        .i_async (rx),
        .o_sync  (w_rx_s)
    );

    assign w_sample    = (r_baud_cnt == '0);
    assign w_handshake = r_data_valid && bus.data_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
        end
    end

    // The first countdown after the falling edge is half a bit, putting every later sample mid-bit.
    always_comb begin
        w_state_next    = r_state;
        w_baud_cnt_next = r_baud_cnt;
        w_bit_cnt_next  = r_bit_cnt;
        w_shift         = 1'b0;
        w_load          = 1'b0;
        w_drop          = 1'b0;
        w_bad_stop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_next    = START;
                    w_baud_cnt_next = CNT_HALF;
                end
            end
            START: begin
                if (w_sample) begin
                    w_baud_cnt_next = CNT_RELOAD;
                    w_bit_cnt_next  = '0;
                    w_state_next    = w_rx_s ? IDLE : DATA;
                end else begin
                    w_baud_cnt_next = r_baud_cnt - 1'b1;
                end
            end
            DATA: begin
                if (w_sample) begin
                    w_shift         = 1'b1;
                    w_baud_cnt_next = CNT_RELOAD;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_bit_cnt_next = '0;
                        w_state_next   = STOP;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end else begin
                    w_baud_cnt_next = r_baud_cnt - 1'b1;
                end
            end
            STOP: begin
                if (w_sample) begin
                    w_baud_cnt_next = CNT_RELOAD;
                    if (w_rx_s) begin
                        w_state_next = IDLE;
                        if (!r_data_valid || bus.data_ready) begin
                            w_load = 1'b1;
                        end else begin
                            w_drop = 1'b1;
                        end
                    end else begin
                        w_bad_stop   = 1'b1;
                        w_state_next = BREAK;
                    end
                end else begin
                    w_baud_cnt_next = r_baud_cnt - 1'b1;
                end
            end
            BREAK: begin
                if (w_rx_s) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // A load in the same cycle as a transfer keeps valid high with the new word.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift         <= '0;
            r_data_bits     <= '0;
            r_data_valid    <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            if (w_shift) begin
                r_shift <= {w_rx_s, r_shift[NUMBER_OF_BITS-1:1]};
            end
            if (w_load) begin
                r_data_bits  <= r_shift;
                r_data_valid <= 1'b1;
            end else if (w_handshake) begin
                r_data_valid <= 1'b0;
            end
            r_framing_error <= w_bad_stop;
            r_overrun       <= w_drop;
        end
    end

    assign bus.data_valid    = r_data_valid;
    assign bus.data_bits     = r_data_bits;
    assign bus.framing_error = r_framing_error;
    assign bus.overrun       = r_overrun;
    assign o_state           = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against uart_rx, checked by a word queue and frame-timing arithmetic.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int NB    = 8;
    localparam int BD    = 4;
    localparam int HALF  = BD / 2;
    localparam int FRAME = (NB + 2) * BD;
    localparam int SYNC  = 2;

    logic           clock = 1'b0;
    logic           reset;
    logic           rx;
    uart_rx_state_t state;

    uart_rx_if #(.NUMBER_OF_BITS(NB)) bus ();

    uart_rx #(
        .NUMBER_OF_BITS (NB),
        .BAUD_DIVIDER   (BD)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .rx      (rx),
        .bus     (bus),
        .o_state (state)
    );

    // clock / reset
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // scoreboard state
    int            n_checks = 0;
    int            n_errors = 0;
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] got_q[$];
    int            rise_q[$];
    int            valid_cycles    = 0;
    int            ferr_cycles     = 0;
    int            ovr_cycles      = 0;
    int            unstable_cycles = 0;
    logic          prev_valid      = 1'b0;
    logic          prev_ready      = 1'b0;
    logic [NB-1:0] prev_bits       = '0;
    int            launch_cyc      = 0;

    // monitor: observe transfers, pulses and buffer stability between clock edges
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.data_valid && bus.data_ready) got_q.push_back(bus.data_bits);
            if (bus.data_valid && !prev_valid) rise_q.push_back(cyc);
            if (bus.data_valid) valid_cycles <= valid_cycles + 1;
            if (bus.framing_error) ferr_cycles <= ferr_cycles + 1;
            if (bus.overrun) ovr_cycles <= ovr_cycles + 1;
            if (prev_valid && !prev_ready && bus.data_valid && bus.data_bits !== prev_bits)
                unstable_cycles <= unstable_cycles + 1;
        end
        prev_valid <= bus.data_valid;
        prev_ready <= bus.data_ready;
        prev_bits  <= bus.data_bits;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drives start, data LSB first, then one stop bit; rx is left at the stop level.
    task automatic send_frame(input logic [NB-1:0] d, input logic stop_bit);
        launch_cyc = cyc;
        rx = 1'b0;
        tick(BD);
        for (int k = 0; k < NB; k++) begin
            rx = d[k];
            tick(BD);
        end
        rx = stop_bit;
        tick(BD);
    endtask

    task automatic check_words(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) check(tag, got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        got_q.delete();
    endtask

    int            f0, o0, v0, r0, launch, gap;
    logic [NB-1:0] d;

    initial begin
        // reset values
        reset = 1'b1;
        rx = 1'b1;
        bus.data_ready = 1'b1;
        tick(3);
        check("rst_valid", bus.data_valid, 1'b0);
        check("rst_ferr", bus.framing_error, 1'b0);
        check("rst_ovr", bus.overrun, 1'b0);
        check("rst_bits", bus.data_bits, '0);
        check("rst_state", state, IDLE);
        reset = 1'b0;
        tick(5);

        // single frame 0x55, ready high: latency from first low rx to valid
        v0 = valid_cycles; f0 = ferr_cycles; r0 = rise_q.size();
        send_frame(8'h55, 1'b1);
        launch = launch_cyc;
        rx = 1'b1;
        tick(6);
        exp_q.push_back(8'h55);
        check("f55_rises", rise_q.size() - r0, 1);
        check("f55_time", (rise_q.size() > r0) ? rise_q[r0] : -1,
              launch + SYNC + HALF + (NB + 1) * BD + 1);
        check("f55_valid_len", valid_cycles - v0, 1);
        check("f55_ferr", ferr_cycles - f0, 0);
        check_words("f55_word");

        // one-cycle glitch on idle line
        v0 = valid_cycles; f0 = ferr_cycles;
        launch = cyc;
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(2);
        check("glitch_start", state, START);
        tick(2);
        check("glitch_idle", state, IDLE);
        tick(10);
        check("glitch_valid", valid_cycles - v0, 0);
        check("glitch_ferr", ferr_cycles - f0, 0);

        // bad stop, line held low (break), then a clean frame
        f0 = ferr_cycles; o0 = ovr_cycles;
        send_frame(8'hA5, 1'b0);
        tick(10);
        check("brk_state", state, BREAK);
        tick(10);
        rx = 1'b1;
        tick(8);
        check("brk_idle", state, IDLE);
        send_frame(8'h3C, 1'b1);
        rx = 1'b1;
        tick(6);
        exp_q.push_back(8'h3C);
        check("brk_ferr", ferr_cycles - f0, 1);
        check("brk_ovr", ovr_cycles - o0, 0);
        check_words("brk_word");

        // back-to-back frames, ready high
        r0 = rise_q.size();
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        rx = 1'b1;
        tick(6);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        check("b2b_rises", rise_q.size() - r0, 2);
        check("b2b_spacing", (rise_q.size() > r0 + 1) ? rise_q[r0 + 1] - rise_q[r0] : -1, FRAME);
        check_words("b2b_word");

        // overrun: second word arrives while the first is still unconsumed
        bus.data_ready = 1'b0;
        o0 = ovr_cycles;
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        rx = 1'b1;
        tick(6);
        check("ovr_pulse", ovr_cycles - o0, 1);
        check("ovr_valid", bus.data_valid, 1'b1);
        check("ovr_bits", bus.data_bits, 8'h12);
        bus.data_ready = 1'b1;
        tick(3);
        check("ovr_drained", bus.data_valid, 1'b0);
        exp_q.push_back(8'h12);
        check_words("ovr_word");

        // transfer in the same cycle as a good stop sample
        bus.data_ready = 1'b0;
        o0 = ovr_cycles;
        send_frame(8'h11, 1'b1);
        rx = 1'b1;
        tick(4);
        send_frame(8'h22, 1'b1);
        bus.data_ready = 1'b1;
        tick(1);
        bus.data_ready = 1'b0;
        check("same_valid", bus.data_valid, 1'b1);
        check("same_bits", bus.data_bits, 8'h22);
        check("same_ovr", ovr_cycles - o0, 0);
        tick(3);
        bus.data_ready = 1'b1;
        tick(2);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        check_words("same_word");

        // reset during data bit 3, then a clean frame
        f0 = ferr_cycles; o0 = ovr_cycles; v0 = valid_cycles;
        rx = 1'b0;
        tick(BD);
        tick(3 * BD);
        tick(2);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        rx = 1'b1;
        tick(12);
        check("mrst_idle", state, IDLE);
        send_frame(8'hF0, 1'b1);
        rx = 1'b1;
        tick(6);
        exp_q.push_back(8'hF0);
        check("mrst_ferr", ferr_cycles - f0, 0);
        check("mrst_ovr", ovr_cycles - o0, 0);
        check("mrst_valid_len", valid_cycles - v0, 1);
        check_words("mrst_word");

        // random words with random idle gaps, ready high
        f0 = ferr_cycles; o0 = ovr_cycles;
        for (int i = 0; i < 8; i++) begin
            d = NB'($urandom_range(0, 255));
            gap = $urandom_range(0, 5);
            send_frame(d, 1'b1);
            rx = 1'b1;
            exp_q.push_back(d);
            if (gap > 0) tick(gap);
        end
        tick(6);
        check("rnd_ferr", ferr_cycles - f0, 0);
        check("rnd_ovr", ovr_cycles - o0, 0);
        check_words("rnd_word");

        check("bits_stable", unstable_cycles, 0);

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
